// File: rtl/rmw_sched_if.sv
// Issue / hazard-check / LSU / ALU handshake bundle for the RMW scheduler.
// slave is the scheduler side; master is the issue, LSU and ALU side.
interface rmw_sched_if;
  logic        iss_valid;
  logic        iss_ready;
  logic [15:0] iss_addr;
  logic [1:0]  iss_fn;
  logic        iss_flags_wr;
  logic [2:0]  iss_flags_tag;
  logic        iss_carry_mask;
  logic [15:0] chk_addr;
  logic        chk_conflict;
  logic        ld_req;
  logic [15:0] ld_addr;
  logic        ld_ack;
  logic        rmw_start;
  logic [15:0] rmw_addr;
  logic [1:0]  rmw_fn;
  logic        rmw_flags_wr;
  logic [2:0]  rmw_flags_tag;
  logic        rmw_carry_mask;
  logic        rmw_data_rdy;
  logic        st_ack;
  logic        busy;
  logic        retired;

  modport slave (
    input  iss_valid, iss_addr, iss_fn, iss_flags_wr, iss_flags_tag, iss_carry_mask,
    input  chk_addr, ld_ack, rmw_data_rdy, st_ack,
    output iss_ready, chk_conflict, ld_req, ld_addr, rmw_start, rmw_addr, rmw_fn,
    output rmw_flags_wr, rmw_flags_tag, rmw_carry_mask, busy, retired
  );

  modport master (
    output iss_valid, iss_addr, iss_fn, iss_flags_wr, iss_flags_tag, iss_carry_mask,
    output chk_addr, ld_ack, rmw_data_rdy, st_ack,
    input  iss_ready, chk_conflict, ld_req, ld_addr, rmw_start, rmw_addr, rmw_fn,
    input  rmw_flags_wr, rmw_flags_tag, rmw_carry_mask, busy, retired
  );
endinterface

// File: rtl/rmw_sched.sv
// RMW micro-op scheduler: FIFO of pending ops, sequenced one at a time through
// LSU load, ALU modify and LSU store, with an address-hazard check for issue.
module rmw_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH) + 2
) (
  input  logic       clk,
  input  logic       a_rst,
  rmw_sched_if.slave bus
);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  fn;
    logic        flags_wr;
    logic [2:0]  flags_tag;
    logic        carry_mask;
  } op_t;

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, STORE} state_t;

  op_t           mem [DEPTH];
  op_t           in_op;
  op_t           head;
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] rd_ptr;
  logic [AW-1:0] count;
  state_t        state;
  state_t        state_n;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          more;
  logic          start;
  logic          retire;
  logic          conflict;

  assign full  = (count == AW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.iss_valid & ~full;
  // Work remains after a pop if more than one entry is queued or one arrives now.
  assign more  = (count > AW'(1)) | push;
  assign head  = empty ? '0 : mem[rd_ptr];

  assign in_op.addr       = bus.iss_addr;
  assign in_op.fn         = bus.iss_fn;
  assign in_op.flags_wr   = bus.iss_flags_wr;
  assign in_op.flags_tag  = bus.iss_flags_tag;
  assign in_op.carry_mask = bus.iss_carry_mask;

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_op;
        wr_ptr      <= wr_ptr + IW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + IW'(1);
      case ({push, pop})
        2'b10:   count <= count + AW'(1);
        2'b01:   count <= count - AW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) state <= IDLE;
    else       state <= state_n;
  end

  // Sequencer: load, start ALU on load ack, wait modified data, wait store accept.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    start   = 1'b0;
    retire  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty || push) state_n = LOAD;
      end
      LOAD: begin
        if (bus.ld_ack) begin
          start   = 1'b1;
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (bus.rmw_data_rdy) begin
          if (bus.st_ack) begin
            pop     = 1'b1;
            retire  = 1'b1;
            state_n = more ? LOAD : IDLE;
          end else begin
            state_n = STORE;
          end
        end
      end
      STORE: begin
        if (bus.st_ack) begin
          pop     = 1'b1;
          retire  = 1'b1;
          state_n = more ? LOAD : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Entry i is live when its distance from the head is below the occupancy.
  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((AW'(IW'(i) - rd_ptr) < count) && (mem[i].addr == bus.chk_addr)) conflict = 1'b1;
    end
  end

  assign bus.iss_ready      = ~full;
  assign bus.chk_conflict   = conflict;
  assign bus.ld_req         = (state == LOAD);
  assign bus.ld_addr        = head.addr;
  assign bus.rmw_start      = start;
  assign bus.rmw_addr       = head.addr;
  assign bus.rmw_fn         = head.fn;
  assign bus.rmw_flags_wr   = head.flags_wr;
  assign bus.rmw_flags_tag  = head.flags_tag;
  assign bus.rmw_carry_mask = head.carry_mask;
  assign bus.busy           = ~empty | (state != IDLE);
  assign bus.retired        = retire;
endmodule

// File: tb/tb_rmw_sched.sv
// Directed bench for rmw_sched: reset, single op, fill, hazard, back-to-back, wrap.
module tb_rmw_sched;
  logic clk = 1'b0;
  logic a_rst;
  int   total = 0;
  int   bad   = 0;

  rmw_sched_if bus ();

  rmw_sched #(.DEPTH(4)) dut (
    .clk  (clk),
    .a_rst(a_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [15:0] a, input logic [1:0] fn, input logic fw,
                     input logic [2:0] tag, input logic cm);
    bus.iss_valid      = 1'b1;
    bus.iss_addr       = a;
    bus.iss_fn         = fn;
    bus.iss_flags_wr   = fw;
    bus.iss_flags_tag  = tag;
    bus.iss_carry_mask = cm;
    tick();
    bus.iss_valid = 1'b0;
    #1;
  endtask

  // Caller is in a LOAD cycle for the op at address a.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [1:0] fn);
    chk({tag, " ld_req"}, 32'(bus.ld_req), 32'd1);
    chk({tag, " ld_addr"}, 32'(bus.ld_addr), 32'(a));
    bus.ld_ack = 1'b1;
    #1;
    chk({tag, " rmw_start"}, 32'(bus.rmw_start), 32'd1);
    chk({tag, " rmw_addr"}, 32'(bus.rmw_addr), 32'(a));
    chk({tag, " rmw_fn"}, 32'(bus.rmw_fn), 32'(fn));
    tick();
    bus.ld_ack       = 1'b0;
    bus.rmw_data_rdy = 1'b1;
    #1;
    chk({tag, " exec no ld_req"}, 32'(bus.ld_req), 32'd0);
    tick();
    bus.rmw_data_rdy = 1'b0;
    bus.st_ack       = 1'b1;
    #1;
    chk({tag, " retired"}, 32'(bus.retired), 32'd1);
    tick();
    bus.st_ack = 1'b0;
    #1;
  endtask

  initial begin
    int issued;
    int starts;
    int rets;
    a_rst              = 1'b1;
    bus.iss_valid      = 1'b0;
    bus.iss_addr       = '0;
    bus.iss_fn         = '0;
    bus.iss_flags_wr   = 1'b0;
    bus.iss_flags_tag  = '0;
    bus.iss_carry_mask = 1'b0;
    bus.chk_addr       = '0;
    bus.ld_ack         = 1'b0;
    bus.rmw_data_rdy   = 1'b0;
    bus.st_ack         = 1'b0;
    tick();
    tick();
    a_rst = 1'b0;
    #1;
    chk("rst iss_ready", 32'(bus.iss_ready), 32'd1);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst ld_req", 32'(bus.ld_req), 32'd0);
    chk("rst rmw_addr", 32'(bus.rmw_addr), 32'd0);
    chk("rst conflict", 32'(bus.chk_conflict), 32'd0);

    // Single INC op
    enq(16'h1234, 2'b00, 1'b0, 3'd0, 1'b0);
    chk("single busy", 32'(bus.busy), 32'd1);
    run_op("single", 16'h1234, 2'b00);
    chk("single busy after", 32'(bus.busy), 32'd0);
    chk("single retired after", 32'(bus.retired), 32'd0);

    // Reset in the middle of EXEC abandons the op
    enq(16'h0ABC, 2'b01, 1'b0, 3'd0, 1'b0);
    bus.ld_ack = 1'b1;
    tick();
    bus.ld_ack = 1'b0;
    #1;
    chk("midrst busy before", 32'(bus.busy), 32'd1);
    a_rst            = 1'b1;
    bus.st_ack       = 1'b1;
    bus.rmw_data_rdy = 1'b1;
    tick();
    a_rst = 1'b0;
    #1;
    chk("midrst retired", 32'(bus.retired), 32'd0);
    chk("midrst iss_ready", 32'(bus.iss_ready), 32'd1);
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst ld_req", 32'(bus.ld_req), 32'd0);
    bus.st_ack       = 1'b0;
    bus.rmw_data_rdy = 1'b0;
    tick();

    // Fill with LSU stalled
    for (int i = 0; i < 4; i++) begin
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 16'h0100 + 16'(i);
      bus.iss_fn    = 2'(i);
      #1;
      chk("fill ready", 32'(bus.iss_ready), 32'd1);
      tick();
    end
    bus.iss_addr = 16'h01FF;
    #1;
    chk("fill full", 32'(bus.iss_ready), 32'd0);
    tick();
    bus.iss_valid = 1'b0;
    #1;
    run_op("fill op0", 16'h0100, 2'd0);
    chk("fill ready after retire", 32'(bus.iss_ready), 32'd1);
    run_op("fill op1", 16'h0101, 2'd1);
    run_op("fill op2", 16'h0102, 2'd2);
    run_op("fill op3", 16'h0103, 2'd3);
    chk("fill 5th dropped", 32'(bus.busy), 32'd0);

    // Address hazards
    enq(16'h0040, 2'b10, 1'b0, 3'd0, 1'b0);
    enq(16'h0080, 2'b11, 1'b0, 3'd0, 1'b0);
    bus.chk_addr = 16'h0080;
    #1;
    chk("haz 0080", 32'(bus.chk_conflict), 32'd1);
    bus.chk_addr = 16'h00C0;
    #1;
    chk("haz 00C0", 32'(bus.chk_conflict), 32'd0);
    bus.chk_addr = 16'h0040;
    #1;
    chk("haz 0040", 32'(bus.chk_conflict), 32'd1);
    run_op("haz op0", 16'h0040, 2'b10);
    bus.chk_addr = 16'h0040;
    #1;
    chk("haz 0040 retired", 32'(bus.chk_conflict), 32'd0);
    bus.chk_addr = 16'h0080;
    #1;
    chk("haz 0080 pending", 32'(bus.chk_conflict), 32'd1);
    run_op("haz op1", 16'h0080, 2'b11);
    chk("haz 0080 retired", 32'(bus.chk_conflict), 32'd0);
    bus.chk_addr = 16'h0000;

    // Back-to-back with coincident data-ready and store-accept
    enq(16'h0500, 2'b01, 1'b0, 3'd0, 1'b0);
    enq(16'h0600, 2'b11, 1'b1, 3'd6, 1'b1);
    bus.ld_ack = 1'b1;
    #1;
    chk("b2b start", 32'(bus.rmw_start), 32'd1);
    chk("b2b fn", 32'(bus.rmw_fn), 32'd1);
    tick();
    #1;
    chk("b2b stray ld_ack", 32'(bus.rmw_start), 32'd0);
    tick();
    bus.ld_ack       = 1'b0;
    bus.rmw_data_rdy = 1'b1;
    bus.st_ack       = 1'b1;
    #1;
    chk("b2b retire", 32'(bus.retired), 32'd1);
    chk("b2b retire addr", 32'(bus.rmw_addr), 32'h0500);
    tick();
    bus.rmw_data_rdy = 1'b0;
    bus.st_ack       = 1'b0;
    #1;
    chk("b2b no bubble", 32'(bus.ld_req), 32'd1);
    chk("b2b flags_wr", 32'(bus.rmw_flags_wr), 32'd1);
    chk("b2b flags_tag", 32'(bus.rmw_flags_tag), 32'd6);
    chk("b2b carry_mask", 32'(bus.rmw_carry_mask), 32'd1);
    run_op("b2b op1", 16'h0600, 2'b11);
    chk("b2b idle", 32'(bus.busy), 32'd0);

    // Stream 3*DEPTH ops with random handshake delays
    issued = 0;
    starts = 0;
    rets   = 0;
    for (int cyc = 0; cyc < 2000 && rets < 12; cyc++) begin
      bus.iss_valid    = (issued < 12) && 1'($urandom_range(0, 1));
      bus.iss_addr     = 16'h2000 + 16'(issued);
      bus.iss_fn       = 2'(issued);
      bus.ld_ack       = 1'($urandom_range(0, 1));
      bus.rmw_data_rdy = 1'($urandom_range(0, 1));
      bus.st_ack       = 1'($urandom_range(0, 1));
      #1;
      if (bus.rmw_start) begin
        chk("wrap single in flight", 32'(starts), 32'(rets));
        chk("wrap start addr", 32'(bus.rmw_addr), 32'h2000 + 32'(starts));
        starts++;
      end
      if (bus.retired) begin
        chk("wrap retire addr", 32'(bus.rmw_addr), 32'h2000 + 32'(rets));
        rets++;
      end
      if (bus.iss_valid && bus.iss_ready) issued++;
      tick();
    end
    bus.iss_valid    = 1'b0;
    bus.ld_ack       = 1'b0;
    bus.rmw_data_rdy = 1'b0;
    bus.st_ack       = 1'b0;
    #1;
    chk("wrap issued", 32'(issued), 32'd12);
    chk("wrap starts", 32'(starts), 32'd12);
    chk("wrap retired", 32'(rets), 32'd12);
    chk("wrap busy", 32'(bus.busy), 32'd0);
    chk("wrap ready", 32'(bus.iss_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
